otter_lsu: RTL and testbench

Load/store unit that initiates all data-port traffic into the OTTER dual-port memory. It accepts one request at a time from the core's memory stage. Misaligned loads and stores are split into aligned word accesses; partial stores are done as read-modify-write. Byte/half extraction, sign extension and write-lane merging are done here, so the memory only ever sees word-sized, word-aligned accesses (IO space excepted).

---
 rtl/otter_lsu_pkg.sv | 33 +++
 rtl/otter_lsu_align.sv | 53 +++++
 rtl/otter_lsu.sv | 174 +++++++++++++++++
 tb/tb_otter_lsu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_lsu_pkg.sv
// rtl/otter_lsu_pkg.sv - shared types and constants for the OTTER load/store unit
// Contents: lsu_state_e FSM encoding, funct3 access codes, default IO base,
//           f3_bytes() access-size helper.
package otter_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_CAPT = 3'd3,
    ST_WR_A = 3'd4,
    ST_WR_B = 3'd5,
    ST_RESP = 3'd6
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

  // Byte count for funct3[1:0]; code 3 is rejected before this matters.
  function automatic logic [2:0] f3_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    f3_bytes = 3'd1;
      2'd1:    f3_bytes = 3'd2;
      default: f3_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/otter_lsu_align.sv
// rtl/otter_lsu_align.sv - combinational load extract and store lane merge
// Ports: words_i   {w1,w0} captured memory words (w0 = lower address)
//        off_i     byte offset of the request inside w0
//        funct3_i  access size / signedness
//        wdata_i   right-justified store data
//        load_o    extracted, sign/zero-extended load result
//        merged0_o / merged1_o  words to write back for a store
module otter_lsu_align
  import otter_lsu_pkg::*;
(
  input  logic [63:0] words_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged0_o,
  output logic [31:0] merged1_o
);

  logic [4:0]  sh;
  logic [31:0] t;
  logic [31:0] lane_mask;
  logic [63:0] mask64;
  logic [63:0] d64;
  logic [63:0] merged;

  always_comb begin
    sh = {off_i, 3'b000};
    t  = 32'(words_i >> sh);
    case (funct3_i[1:0])
      F3_B[1:0]: begin
        lane_mask = 32'h0000_00FF;
        load_o    = {{24{t[7] & ~funct3_i[2]}}, t[7:0]};
      end
      F3_H[1:0]: begin
        lane_mask = 32'h0000_FFFF;
        load_o    = {{16{t[15] & ~funct3_i[2]}}, t[15:0]};
      end
      default: begin
        lane_mask = 32'hFFFF_FFFF;
        load_o    = t;
      end
    endcase
    // Little-endian lanes: bytes that spill past w0 land in the low lanes of w1.
    mask64 = {32'd0, lane_mask} << sh;
    d64    = {32'd0, wdata_i} << sh;
    merged = (words_i & ~mask64) | (d64 & mask64);
  end

  assign merged0_o = merged[31:0];
  assign merged1_o = merged[63:32];

endmodule

// File: rtl/otter_lsu.sv
// rtl/otter_lsu.sv - OTTER load/store unit: splits misaligned accesses, RMW partial stores
// Config macro: LSU_FAST_STORE_EN (non-IO, non-spanning stores use memory lane enables).
// Ports: MEM_CLK, MEM_RST_N (async active-low)
//        LSU_REQ/WE/ADDR/WDATA/FUNCT3 request in; LSU_BUSY/DONE/ERR/RDATA status out
//        MEM_ADDR2/DIN2/WRITE2/READ2/SIZE/SIGN memory data port out; MEM_DOUT2 read data in
module otter_lsu
  import otter_lsu_pkg::*;
#(
  parameter int          ACTUAL_WIDTH = 14,
  parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT
) (
  input  logic        MEM_CLK,
  input  logic        MEM_RST_N,
  input  logic        LSU_REQ,
  input  logic        LSU_WE,
  input  logic [31:0] LSU_ADDR,
  input  logic [31:0] LSU_WDATA,
  input  logic [2:0]  LSU_FUNCT3,
  output logic        LSU_BUSY,
  output logic        LSU_DONE,
  output logic        LSU_ERR,
  output logic [31:0] LSU_RDATA,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  localparam logic [32:0] MEM_LIMIT = 33'd1 << (ACTUAL_WIDTH + 2);
`ifdef LSU_FAST_STORE_EN
  localparam logic FAST_STORE = 1'b1;
`else
  localparam logic FAST_STORE = 1'b0;
`endif

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q, w0_q, w1_q, rdata_q;
  logic [2:0]  f3_q;
  logic        we_q, io_q, span_q, err_q, fast_q;

  // Request decode, evaluated on the raw inputs so it can be latched in IDLE.
  logic [2:0]  req_n;
  logic        req_io, req_span, req_bad_f3, req_err, req_fast;
  logic [32:0] req_wb;

  always_comb begin
    req_n      = f3_bytes(LSU_FUNCT3[1:0]);
    req_io     = LSU_ADDR >= IO_BASE;
    req_span   = ({1'b0, LSU_ADDR[1:0]} + req_n) > 3'd4;
    req_wb     = {1'b0, LSU_ADDR[31:2], 2'b00} + 33'd4;  // 33 bits: no wrap to 0
    req_bad_f3 = !(LSU_FUNCT3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    req_err    = req_bad_f3
              || (!req_io && ({1'b0, LSU_ADDR} >= MEM_LIMIT))
              || (!req_io && req_span && (req_wb >= MEM_LIMIT));
    req_fast   = FAST_STORE && LSU_WE && !req_io && !req_span;
  end

  logic [31:0] word_a, word_b, align_load, merged0, merged1, load_val;

  assign word_a = {addr_q[31:2], 2'b00};
  assign word_b = word_a + 32'd4;

  otter_lsu_align u_align (
    .words_i   ({w1_q, w0_q}),
    .off_i     (addr_q[1:0]),
    .funct3_i  (f3_q),
    .wdata_i   (wdata_q),
    .load_o    (align_load),
    .merged0_o (merged0),
    .merged1_o (merged1)
  );

  assign load_val = io_q ? w0_q : align_load;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (LSU_REQ) begin
        if (req_err)                  state_d = ST_RESP;
        else if (LSU_WE && (req_io || req_fast)) state_d = ST_WR_A;
        else                          state_d = ST_RD_A;
      end
      ST_RD_A: state_d = span_q ? ST_RD_B : ST_CAPT;
      ST_RD_B: state_d = ST_CAPT;
      ST_CAPT: state_d = we_q ? ST_WR_A : ST_RESP;
      ST_WR_A: state_d = span_q ? ST_WR_B : ST_RESP;
      ST_WR_B: state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      span_q  <= 1'b0;
      err_q   <= 1'b0;
      fast_q  <= 1'b0;
      w0_q    <= '0;
      w1_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (LSU_REQ) begin
          addr_q  <= LSU_ADDR;
          wdata_q <= LSU_WDATA;
          f3_q    <= LSU_FUNCT3;
          we_q    <= LSU_WE;
          io_q    <= req_io;
          span_q  <= req_span && !req_io;  // IO space is never split
          err_q   <= req_err;
          fast_q  <= req_fast;
        end
        ST_RD_B: w0_q <= MEM_DOUT2;
        ST_CAPT: if (span_q) w1_q <= MEM_DOUT2; else w0_q <= MEM_DOUT2;
        ST_RESP: if (!we_q && !err_q) rdata_q <= load_val;
        default: ;
      endcase
    end
  end

  always_comb begin
    MEM_ADDR2  = '0;
    MEM_DIN2   = '0;
    MEM_WRITE2 = 1'b0;
    MEM_READ2  = 1'b0;
    MEM_SIZE   = 2'd0;
    LSU_DONE   = 1'b0;
    LSU_ERR    = 1'b0;
    case (state_q)
      ST_RD_A: begin
        MEM_READ2 = 1'b1;
        MEM_ADDR2 = io_q ? addr_q : word_a;
        MEM_SIZE  = 2'd2;
      end
      ST_RD_B: begin
        MEM_READ2 = 1'b1;
        MEM_ADDR2 = word_b;
        MEM_SIZE  = 2'd2;
      end
      ST_WR_A: begin
        MEM_WRITE2 = 1'b1;
        MEM_ADDR2  = (io_q || fast_q) ? addr_q  : word_a;
        MEM_DIN2   = (io_q || fast_q) ? wdata_q : merged0;
        MEM_SIZE   = fast_q ? f3_q[1:0] : 2'd2;
      end
      ST_WR_B: begin
        MEM_WRITE2 = 1'b1;
        MEM_ADDR2  = word_b;
        MEM_DIN2   = merged1;
        MEM_SIZE   = 2'd2;
      end
      ST_RESP: begin
        LSU_DONE = 1'b1;
        LSU_ERR  = err_q;
      end
      default: ;
    endcase
  end

  assign LSU_BUSY  = state_q != ST_IDLE;
  assign MEM_SIGN  = 1'b0;
  // The fresh result is visible during the DONE cycle and held afterwards.
  assign LSU_RDATA = (state_q == ST_RESP && !we_q && !err_q) ? load_val : rdata_q;

endmodule

// File: tb/tb_otter_lsu.sv
// tb/tb_otter_lsu.sv - directed and randomized self-checking bench for otter_lsu
module tb_otter_lsu;

  localparam logic [31:0] IO_BASE = 32'h1100_0000;
  localparam longint      LIMIT   = 64'h1_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        LSU_REQ = 1'b0, LSU_WE = 1'b0;
  logic [31:0] LSU_ADDR = '0, LSU_WDATA = '0;
  logic [2:0]  LSU_FUNCT3 = '0;
  logic        LSU_BUSY, LSU_DONE, LSU_ERR;
  logic [31:0] LSU_RDATA, MEM_ADDR2, MEM_DIN2;
  logic        MEM_WRITE2, MEM_READ2, MEM_SIGN;
  logic [1:0]  MEM_SIZE;
  logic [31:0] MEM_DOUT2 = '0;

  always #5 clk = ~clk;

  otter_lsu dut (
    .MEM_CLK(clk), .MEM_RST_N(rst_n),
    .LSU_REQ(LSU_REQ), .LSU_WE(LSU_WE), .LSU_ADDR(LSU_ADDR),
    .LSU_WDATA(LSU_WDATA), .LSU_FUNCT3(LSU_FUNCT3),
    .LSU_BUSY(LSU_BUSY), .LSU_DONE(LSU_DONE), .LSU_ERR(LSU_ERR),
    .LSU_RDATA(LSU_RDATA), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_WRITE2(MEM_WRITE2), .MEM_READ2(MEM_READ2), .MEM_SIZE(MEM_SIZE),
    .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2)
  );

  // Word memory seen by the DUT; only this block writes it.
  logic [31:0] mem [0:16383];
  logic        init_req = 1'b0, poke_en = 1'b0;
  logic [31:0] poke_addr = '0, poke_data = '0, io_val = '0, io_wr = '0;

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  always @(posedge clk) begin
    if (init_req) for (int i = 0; i < 16384; i++) mem[i] <= pat(i);
    else if (poke_en) mem[poke_addr[15:2]] <= poke_data;
    if (MEM_WRITE2) begin
      if (MEM_ADDR2 >= IO_BASE) io_wr <= MEM_DIN2;
      else if (MEM_ADDR2 < 32'(LIMIT)) mem[MEM_ADDR2[15:2]] <= MEM_DIN2;
    end
    if (MEM_READ2)
      MEM_DOUT2 <= (MEM_ADDR2 >= IO_BASE) ? io_val :
                   (MEM_ADDR2 < 32'(LIMIT)) ? mem[MEM_ADDR2[15:2]] : 32'h0;
  end

  // Byte-addressed reference memory.
  logic [7:0] rb [0:65535];

  int tests = 0, fails = 0;
  int done_cyc, n_rd, n_wr, first_wr_cyc;
  logic [31:0] got_rdata, rd_addr0, rd_addr1, wr_addr0, wr_din0;
  logic [1:0]  rd_size;
  logic        got_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int nb(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    int n = nb(f3);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(rb[a + 32'(i)]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    for (int i = 0; i < nb(f3); i++) rb[a + 32'(i)] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] rb_word(input logic [31:0] w);
    return {rb[w+3], rb[w+2], rb[w+1], rb[w]};
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    for (int i = 0; i < 4; i++) rb[a + 32'(i)] = d[8*i +: 8];
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3);
    @(negedge clk);
    LSU_REQ = 1'b1; LSU_WE = we; LSU_ADDR = a; LSU_WDATA = wd; LSU_FUNCT3 = f3;
    @(posedge clk);
    #1 LSU_REQ = 1'b0;
    done_cyc = 0; n_rd = 0; n_wr = 0; first_wr_cyc = 0;
    rd_addr0 = '0; rd_addr1 = '0; wr_addr0 = '0; wr_din0 = '0; rd_size = '0;
    got_rdata = '0; got_err = 1'b0;
    for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (MEM_READ2) begin
        if (n_rd == 0) begin rd_addr0 = MEM_ADDR2; rd_size = MEM_SIZE; end
        else rd_addr1 = MEM_ADDR2;
        n_rd++;
      end
      if (MEM_WRITE2) begin
        if (n_wr == 0) begin first_wr_cyc = c; wr_addr0 = MEM_ADDR2; wr_din0 = MEM_DIN2; end
        n_wr++;
      end
      if (LSU_DONE) begin done_cyc = c; got_rdata = LSU_RDATA; got_err = LSU_ERR; end
    end
    if (done_cyc == 0) chk("done_timeout", 32'(done_cyc), 32'd1);
  endtask

  logic [2:0] f3_tab [11] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  initial begin
    rst_n = 1'b0;
    init_req = 1'b1;
    for (int i = 0; i < 16384; i++) begin
      logic [31:0] p;
      p = pat(i);
      for (int k = 0; k < 4; k++) rb[4*i + k] = p[8*k +: 8];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    init_req = 1'b0;
    chk("reset_status", {29'd0, LSU_BUSY, LSU_DONE, LSU_ERR}, 32'd0);
    chk("reset_rdata", LSU_RDATA, 32'd0);
    chk("reset_mem_ctl", {27'd0, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN}, 32'd0);
    chk("reset_mem_addr_din", MEM_ADDR2 | MEM_DIN2, 32'd0);
    rst_n = 1'b1;

    poke(32'h100, 32'hDEAD_BEEF);
    poke(32'h104, 32'h1122_3344);

    run_req(1'b0, 32'h100, 32'h0, 3'd2);
    chk("lw_lat", 32'(done_cyc), 32'd3);
    chk("lw_data", got_rdata, 32'hDEAD_BEEF);
    chk("lw_reads", 32'(n_rd), 32'd1);
    chk("lw_writes", 32'(n_wr), 32'd0);
    chk("lw_raddr", rd_addr0, 32'h100);
    chk("lw_size", 32'(rd_size), 32'd2);
    @(negedge clk);
    chk("rdata_held", LSU_RDATA, 32'hDEAD_BEEF);

    run_req(1'b0, 32'h103, 32'h0, 3'd0);
    chk("lb_data", got_rdata, 32'hFFFF_FFDE);
    run_req(1'b0, 32'h103, 32'h0, 3'd4);
    chk("lbu_data", got_rdata, 32'h0000_00DE);
    run_req(1'b0, 32'h102, 32'h0, 3'd1);
    chk("lh_data", got_rdata, 32'hFFFF_DEAD);

    run_req(1'b0, 32'h102, 32'h0, 3'd2);
    chk("lw_mis_data", got_rdata, 32'h3344_DEAD);
    chk("lw_mis_lat", 32'(done_cyc), 32'd4);
    chk("lw_mis_raddr0", rd_addr0, 32'h100);
    chk("lw_mis_raddr1", rd_addr1, 32'h104);

    run_req(1'b1, 32'h103, 32'hAABB_CCDD, 3'd2);
    ref_store(32'h103, 3'd2, 32'hAABB_CCDD);
    chk("sw_mis_lat", 32'(done_cyc), 32'd6);
    chk("sw_mis_w0", mem[32'h100 >> 2], 32'hDDAD_BEEF);
    chk("sw_mis_w1", mem[32'h104 >> 2], 32'h11AA_BBCC);

    run_req(1'b1, 32'h1100_0020, 32'h5, 3'd2);
    chk("io_sw_lat", 32'(done_cyc), 32'd2);
    chk("io_sw_wcyc", 32'(first_wr_cyc), 32'd1);
    chk("io_sw_waddr", wr_addr0, 32'h1100_0020);
    chk("io_sw_wdin", wr_din0, 32'h5);
    chk("io_sw_reads", 32'(n_rd), 32'd0);
    io_val = 32'h1234;
    run_req(1'b0, 32'h1100_0020, 32'h0, 3'd2);
    chk("io_lw_data", got_rdata, 32'h1234);
    chk("io_lw_lat", 32'(done_cyc), 32'd3);

    run_req(1'b0, 32'h0000_FFFE, 32'h0, 3'd2);
    chk("err_top_flag", 32'(got_err), 32'd1);
    chk("err_top_strobes", 32'(n_rd + n_wr), 32'd0);
    chk("err_top_lat", 32'(done_cyc), 32'd1);
    run_req(1'b0, 32'h100, 32'h0, 3'd3);
    chk("err_f3_flag", 32'(got_err), 32'd1);

    // Reset in the middle of a spanning load, while in the second read.
    @(negedge clk);
    LSU_REQ = 1'b1; LSU_WE = 1'b0; LSU_ADDR = 32'h102; LSU_FUNCT3 = 3'd2;
    @(posedge clk);
    #1 LSU_REQ = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rd_b_addr", MEM_ADDR2, 32'h104);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_status", {28'd0, LSU_BUSY, LSU_DONE, LSU_ERR, MEM_READ2}, 32'd0);
    chk("mid_rst_rdata", LSU_RDATA, 32'd0);
    chk("mid_rst_addr", MEM_ADDR2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(LSU_BUSY), 32'd0);

    for (int it = 0; it < 80; it++) begin
      int sel, n, lat, erd, ewr;
      logic [31:0] a, wd, exp_data;
      logic [2:0] f3;
      logic we, io, span, e;
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      a = 32'h200 + $urandom_range(0, 31);
      else if (sel <= 7) a = 32'hFFF0 + $urandom_range(0, 19);
      else if (sel == 8) a = IO_BASE + $urandom_range(0, 63);
      else               a = 32'h0020_0000 + $urandom_range(0, 15);
      f3 = f3_tab[$urandom_range(0, 10)];
      we = 1'(($urandom_range(0, 1)));
      wd = $urandom;
      io_val = $urandom;
      n = nb(f3);
      io = a >= IO_BASE;
      span = (int'(a[1:0]) + n) > 4;
      e = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ||
          (!io && (longint'(a) + longint'(n) - 1 >= LIMIT));
      exp_data = (!e && !io && !we) ? ref_load(a, f3) : 32'h0;
      if (e)       begin lat = 1; erd = 0; ewr = 0; end
      else if (io) begin lat = we ? 2 : 3; erd = we ? 0 : 1; ewr = we ? 1 : 0; end
      else if (we) begin lat = span ? 6 : 4; erd = span ? 2 : 1; ewr = erd; end
      else         begin lat = span ? 4 : 3; erd = span ? 2 : 1; ewr = 0; end
      run_req(we, a, wd, f3);
      chk($sformatf("rnd%0d_lat", it), 32'(done_cyc), 32'(lat));
      chk($sformatf("rnd%0d_err", it), 32'(got_err), 32'(e));
      chk($sformatf("rnd%0d_nrd", it), 32'(n_rd), 32'(erd));
      chk($sformatf("rnd%0d_nwr", it), 32'(n_wr), 32'(ewr));
      if (!e && !we) chk($sformatf("rnd%0d_rdata", it), got_rdata, io ? io_val : exp_data);
      if (!e && we && io) chk($sformatf("rnd%0d_iowr", it), io_wr, wd);
      if (!e && we && !io) begin
        logic [31:0] wa;
        ref_store(a, f3, wd);
        wa = {a[31:2], 2'b00};
        chk($sformatf("rnd%0d_memA", it), mem[wa[15:2]], rb_word(wa));
        if (span) chk($sformatf("rnd%0d_memB", it), mem[wa[15:2] + 14'd1], rb_word(wa + 32'd4));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
